// File: rtl/control_pipeline_pkg.sv
// -----------------------------------------------------------------------------
// control_pipeline_pkg
//   Shared definitions for the pipeline sequencer and the hazard logic:
//   FSM state encoding, default drain length and NOP-related constants.
// -----------------------------------------------------------------------------
package control_pipeline_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP_WAIT = 3'd2,
        ST_STEP_EXEC = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_HALTED    = 3'd5
    } estado_t;

    // Cycles a HALT needs after reaching ID until it retires from WB.
    localparam int CANT_CICLOS_DRENAJE_DEF = 4;
    localparam int CANT_BITS_DRENAJE_DEF   = 3;

    // NOP encoding loaded into IF/ID on flush (sll $0,$0,0).
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
    // Level of o_bit_burbuja that requests a load-use stall.
    localparam logic BIT_BURBUJA_ACTIVO = 1'b1;

    // States in which the pipeline takes a normal (hazard-aware) step.
    function automatic logic es_avance(input estado_t e);
        return (e == ST_RUN) || (e == ST_STEP_EXEC);
    endfunction

endpackage

// File: rtl/control_pipeline_contador_saturado.sv
// -----------------------------------------------------------------------------
// contador_saturado
//   Up-counter that sticks at all-ones instead of wrapping.
//   i_clock     : rising-edge clock
//   i_reset     : asynchronous active-low reset (count -> 0)
//   i_limpiar   : synchronous clear, wins over i_habilitar
//   i_habilitar : count one when set
//   o_cuenta    : current count
// -----------------------------------------------------------------------------
module contador_saturado #(
    parameter int ANCHO = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_limpiar,
    input  logic             i_habilitar,
    output logic [ANCHO-1:0] o_cuenta
);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_cuenta <= '0;
        end else if (i_limpiar) begin
            o_cuenta <= '0;
        end else if (i_habilitar && (o_cuenta != '1)) begin
            o_cuenta <= o_cuenta + 1'b1;
        end
    end

endmodule

// File: rtl/control_pipeline.sv
// -----------------------------------------------------------------------------
// control_pipeline
//   Sequences the 5-stage MIPS pipeline: per-stage write enables, IF/ID flush,
//   ID/EX bubble, continuous / step execution, HALT drain and statistics.
//   Inputs : i_clock, i_reset (async, active low), i_start, i_modo_ejecucion
//            (0 continuous, 1 step), i_paso (step level), i_bit_burbuja,
//            i_branch_taken_id, i_halt_id
//   Outputs: o_enable_{pc,if_id,id_ex,ex_mem,mem_wb}, o_flush_if_id,
//            o_burbuja_id_ex, o_halt, o_contador_ciclos, o_contador_burbujas
//   Handshake: none; i_start is a single-cycle pulse honoured only in IDLE
//   and HALTED, outputs are a same-cycle decode of state and inputs.
// -----------------------------------------------------------------------------
import control_pipeline_pkg::*;

module control_pipeline #(
    parameter int CANT_BITS_CONTADOR  = 32,
    parameter int CANT_CICLOS_DRENAJE = CANT_CICLOS_DRENAJE_DEF,
    parameter int CANT_BITS_DRENAJE   = CANT_BITS_DRENAJE_DEF
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic                          i_modo_ejecucion,
    input  logic                          i_paso,
    input  logic                          i_bit_burbuja,
    input  logic                          i_branch_taken_id,
    input  logic                          i_halt_id,
    output logic                          o_enable_pc,
    output logic                          o_enable_if_id,
    output logic                          o_enable_id_ex,
    output logic                          o_enable_ex_mem,
    output logic                          o_enable_mem_wb,
    output logic                          o_flush_if_id,
    output logic                          o_burbuja_id_ex,
    output logic                          o_halt,
    output logic [CANT_BITS_CONTADOR-1:0] o_contador_ciclos,
    output logic [CANT_BITS_CONTADOR-1:0] o_contador_burbujas
);

    estado_t                estado;
    estado_t                estado_sig;
    logic [CANT_BITS_DRENAJE-1:0] cuenta_drenaje;
    logic                   paso_prev;
    logic                   flanco_paso;
    logic                   burbuja;
    logic                   limpiar_contadores;
    logic                   inc_ciclos;
    logic                   inc_burbujas;

    assign burbuja     = (i_bit_burbuja == BIT_BURBUJA_ACTIVO);
    // One step per low-to-high transition; a held level yields a single step.
    assign flanco_paso = i_paso && !paso_prev;

    // ---------------------------------------------------------------- state
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            estado <= ST_IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            paso_prev <= 1'b0;
        end else begin
            paso_prev <= i_paso;
        end
    end

    // Loaded with N-1 on entry so DRAIN lasts exactly N cycles (N-1 .. 0).
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cuenta_drenaje <= '0;
        end else if (estado != ST_DRAIN && estado_sig == ST_DRAIN) begin
            cuenta_drenaje <= CANT_BITS_DRENAJE'(CANT_CICLOS_DRENAJE - 1);
        end else if (estado == ST_DRAIN && cuenta_drenaje != '0) begin
            cuenta_drenaje <= cuenta_drenaje - 1'b1;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        estado_sig = estado;
        case (estado)
            ST_IDLE: begin
                if (i_start) begin
                    estado_sig = i_modo_ejecucion ? ST_STEP_WAIT : ST_RUN;
                end
            end
            ST_RUN: begin
                // A stalled cycle holds the ID instruction, so halt waits.
                if (!burbuja && i_halt_id) begin
                    estado_sig = ST_DRAIN;
                end
            end
            ST_STEP_WAIT: begin
                if (flanco_paso) begin
                    estado_sig = ST_STEP_EXEC;
                end
            end
            ST_STEP_EXEC: begin
                estado_sig = (!burbuja && i_halt_id) ? ST_DRAIN : ST_STEP_WAIT;
            end
            ST_DRAIN: begin
                if (cuenta_drenaje == '0) begin
                    estado_sig = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (i_start) begin
                    estado_sig = ST_IDLE;
                end
            end
            default: estado_sig = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        o_enable_pc        = 1'b0;
        o_enable_if_id     = 1'b0;
        o_enable_id_ex     = 1'b0;
        o_enable_ex_mem    = 1'b0;
        o_enable_mem_wb    = 1'b0;
        o_flush_if_id      = 1'b0;
        o_burbuja_id_ex    = 1'b0;
        o_halt             = 1'b0;
        limpiar_contadores = 1'b0;
        inc_ciclos         = 1'b0;
        inc_burbujas       = 1'b0;

        if (es_avance(estado)) begin
            o_enable_id_ex  = 1'b1;
            o_enable_ex_mem = 1'b1;
            o_enable_mem_wb = 1'b1;
            inc_ciclos      = 1'b1;
            if (burbuja) begin
                o_burbuja_id_ex = 1'b1;
                inc_burbujas    = 1'b1;
            end else if (!i_halt_id) begin
                // Halt freezes fetch; otherwise fetch advances and a taken
                // branch discards the wrong-path instruction in IF/ID.
                o_enable_pc    = 1'b1;
                o_enable_if_id = 1'b1;
                o_flush_if_id  = i_branch_taken_id;
            end
        end else if (estado == ST_DRAIN) begin
            // Feed NOPs behind the HALT while the back end empties.
            o_enable_id_ex  = 1'b1;
            o_burbuja_id_ex = 1'b1;
            o_enable_ex_mem = 1'b1;
            o_enable_mem_wb = 1'b1;
            inc_ciclos      = 1'b1;
        end else if (estado == ST_HALTED) begin
            o_halt             = 1'b1;
            limpiar_contadores = i_start;
        end else if (estado == ST_IDLE) begin
            limpiar_contadores = i_start;
        end
    end

    contador_saturado #(
        .ANCHO(CANT_BITS_CONTADOR)
    ) u_contador_ciclos (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_limpiar  (limpiar_contadores),
        .i_habilitar(inc_ciclos),
        .o_cuenta   (o_contador_ciclos)
    );

    contador_saturado #(
        .ANCHO(CANT_BITS_CONTADOR)
    ) u_contador_burbujas (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_limpiar  (limpiar_contadores),
        .i_habilitar(inc_burbujas),
        .o_cuenta   (o_contador_burbujas)
    );

endmodule

// File: tb/tb_control_pipeline.sv
module tb_control_pipeline;

    // Narrow counters so saturation is reachable in a short run.
    localparam int W  = 5;
    localparam int VW = 8 + 2 * W;
    localparam int MAXC = (1 << W) - 1;

    logic         i_clock = 1'b0;
    logic         i_reset = 1'b0;
    logic         i_start = 1'b0;
    logic         i_modo_ejecucion = 1'b0;
    logic         i_paso = 1'b0;
    logic         i_bit_burbuja = 1'b0;
    logic         i_branch_taken_id = 1'b0;
    logic         i_halt_id = 1'b0;
    logic         o_enable_pc, o_enable_if_id, o_enable_id_ex;
    logic         o_enable_ex_mem, o_enable_mem_wb;
    logic         o_flush_if_id, o_burbuja_id_ex, o_halt;
    logic [W-1:0] o_contador_ciclos, o_contador_burbujas;

    int checks = 0;
    int failures = 0;
    int ncycle = 0;
    logic [VW-1:0] exp_q[$];

    // Reference model: phase name, counters, drain steps left, last step level.
    string m_fase = "idle";
    int    m_cyc = 0;
    int    m_bub = 0;
    int    m_dren = 0;
    logic  m_paso_prev = 1'b0;

    control_pipeline #(
        .CANT_BITS_CONTADOR(W)
    ) dut (
        .i_clock            (i_clock),
        .i_reset            (i_reset),
        .i_start            (i_start),
        .i_modo_ejecucion   (i_modo_ejecucion),
        .i_paso             (i_paso),
        .i_bit_burbuja      (i_bit_burbuja),
        .i_branch_taken_id  (i_branch_taken_id),
        .i_halt_id          (i_halt_id),
        .o_enable_pc        (o_enable_pc),
        .o_enable_if_id     (o_enable_if_id),
        .o_enable_id_ex     (o_enable_id_ex),
        .o_enable_ex_mem    (o_enable_ex_mem),
        .o_enable_mem_wb    (o_enable_mem_wb),
        .o_flush_if_id      (o_flush_if_id),
        .o_burbuja_id_ex    (o_burbuja_id_ex),
        .o_halt             (o_halt),
        .o_contador_ciclos  (o_contador_ciclos),
        .o_contador_burbujas(o_contador_burbujas)
    );

    // ------------------------------------------------------ clock / reset
    always #5 i_clock = ~i_clock;

    function automatic logic [VW-1:0] actual_vec();
        return {o_enable_pc, o_enable_if_id, o_enable_id_ex, o_enable_ex_mem,
                o_enable_mem_wb, o_flush_if_id, o_burbuja_id_ex, o_halt,
                o_contador_ciclos, o_contador_burbujas};
    endfunction

    // ------------------------------------------------------------ model
    task automatic modelo();
        logic pc, ifid, idex, exmem, memwb, fl, bu, ha;
        logic edge_p;
        bit   adv;
        pc = 0; ifid = 0; idex = 0; exmem = 0; memwb = 0; fl = 0; bu = 0; ha = 0;
        adv = (m_fase == "run") || (m_fase == "exec");
        edge_p = i_paso && !m_paso_prev;
        if (adv) begin
            idex = 1; exmem = 1; memwb = 1;
            if (i_bit_burbuja) bu = 1;
            else if (!i_halt_id) begin
                pc = 1; ifid = 1; fl = i_branch_taken_id;
            end
        end else if (m_fase == "drain") begin
            idex = 1; exmem = 1; memwb = 1; bu = 1;
        end else if (m_fase == "halted") begin
            ha = 1;
        end
        exp_q.push_back({pc, ifid, idex, exmem, memwb, fl, bu, ha,
                         W'(m_cyc), W'(m_bub)});

        // Advance to next cycle.
        if (m_fase == "idle") begin
            if (i_start) begin
                m_fase = i_modo_ejecucion ? "wait" : "run";
                m_cyc = 0; m_bub = 0;
            end
        end else if (adv) begin
            if (m_cyc < MAXC) m_cyc++;
            if (i_bit_burbuja) begin
                if (m_bub < MAXC) m_bub++;
                if (m_fase == "exec") m_fase = "wait";
            end else if (i_halt_id) begin
                m_fase = "drain";
                m_dren = 4;
            end else if (m_fase == "exec") begin
                m_fase = "wait";
            end
        end else if (m_fase == "wait") begin
            if (edge_p) m_fase = "exec";
        end else if (m_fase == "drain") begin
            if (m_cyc < MAXC) m_cyc++;
            m_dren--;
            if (m_dren == 0) m_fase = "halted";
        end else if (m_fase == "halted") begin
            if (i_start) begin
                m_fase = "idle"; m_cyc = 0; m_bub = 0;
            end
        end
        m_paso_prev = i_paso;
    endtask

    task automatic modelo_reset();
        m_fase = "idle"; m_cyc = 0; m_bub = 0; m_dren = 0; m_paso_prev = 1'b0;
    endtask

    // ------------------------------------------------------------ drivers
    task automatic ciclo(input logic s, input logic m, input logic p,
                         input logic bb, input logic br, input logic h);
        @(posedge i_clock);
        #2;
        i_start = s; i_modo_ejecucion = m; i_paso = p;
        i_bit_burbuja = bb; i_branch_taken_id = br; i_halt_id = h;
        modelo();
    endtask

    task automatic inactivo(input int n);
        for (int i = 0; i < n; i++) ciclo(0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset(input string nombre);
        checks++;
        if (actual_vec() !== '0) begin
            failures++;
            $display("FAIL %s: outputs got %h expected %h", nombre, actual_vec(), {VW{1'b0}});
        end
    endtask

    // Reset asserted between clock edges: outputs must clear without a clock.
    task automatic reset_asincrono();
        @(posedge i_clock);
        #2;
        i_reset = 1'b0;
        #1;
        check_reset("async_reset");
        modelo_reset();
        i_start = 0; i_paso = 0; i_bit_burbuja = 0; i_branch_taken_id = 0; i_halt_id = 0;
        repeat (2) @(posedge i_clock);
        #2;
        i_reset = 1'b1;
    endtask

    // ------------------------------------------------------------ scoreboard
    always @(negedge i_clock) begin
        logic [VW-1:0] e;
        ncycle++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (actual_vec() !== e) begin
                failures++;
                $display("FAIL outputs cyc%0d: got en=%b fl=%b bu=%b h=%b c=%0d b=%0d expected en=%b fl=%b bu=%b h=%b c=%0d b=%0d",
                         ncycle, actual_vec()[VW-1 -: 5], actual_vec()[VW-6], actual_vec()[VW-7],
                         actual_vec()[VW-8], o_contador_ciclos, o_contador_burbujas,
                         e[VW-1 -: 5], e[VW-6], e[VW-7], e[VW-8], e[2*W-1 -: W], e[W-1:0]);
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        logic m, p;
        int   budget;

        // Power-on reset for 3 clocks.
        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        check_reset("power_on_reset");
        @(posedge i_clock);
        #2;
        i_reset = 1'b1;
        inactivo(3);

        // Continuous mode: load-use stall, branch hidden by stall, branch alone.
        ciclo(1, 0, 0, 0, 0, 0);
        inactivo(2);
        ciclo(0, 0, 0, 1, 0, 0);
        inactivo(1);
        ciclo(0, 0, 0, 1, 1, 0);
        ciclo(0, 0, 0, 0, 1, 0);
        ciclo(0, 0, 0, 0, 0, 1);
        ciclo(1, 0, 0, 1, 1, 1);   // start ignored while draining
        inactivo(5);
        ciclo(1, 0, 0, 0, 0, 0);   // re-arm after halt
        inactivo(2);

        // Step mode: held high = one step, then a second edge.
        ciclo(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) ciclo(0, 0, 1, 0, 0, 0);
        inactivo(2);
        for (int i = 0; i < 3; i++) ciclo(0, 0, 1, 0, 0, 0);
        ciclo(0, 0, 0, 0, 0, 0);
        ciclo(0, 0, 1, 0, 0, 0);
        ciclo(0, 0, 1, 0, 0, 1);   // step executes the HALT
        inactivo(2);               // mid-drain
        reset_asincrono();
        inactivo(2);

        // Saturation: run long enough to pin both counters at all-ones.
        ciclo(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < MAXC + 4; i++) ciclo(0, 0, 0, 1, 0, 0);
        inactivo(3);
        ciclo(0, 0, 0, 0, 0, 1);
        inactivo(6);
        ciclo(1, 0, 0, 0, 0, 0);
        inactivo(1);

        // Randomized runs in both modes.
        for (int r = 0; r < 12; r++) begin
            m = 1'($urandom_range(0, 1));
            ciclo(1, m, 0, 0, 0, 0);
            p = 1'b0;
            budget = 0;
            while (m_fase != "halted" && budget < 400) begin
                if ($urandom_range(0, 2) == 0) p = ~p;
                ciclo(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), p,
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, (budget > 150) ? 1 : 12) == 0));
                budget++;
            end
            checks++;
            if (m_fase != "halted") begin
                failures++;
                $display("FAIL random_run%0d: reached halt=0 required halt=1 within budget", r);
            end
            inactivo($urandom_range(0, 3));
            ciclo(1, 0, 0, 0, 0, 0);
            inactivo(1);
        end

        inactivo(2);
        @(posedge i_clock);
        @(posedge i_clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: pending got %0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
